// File: rtl/rd_ctrl_v2.sv
// rd_ctrl_v2 -- read-side controller for an asynchronous FIFO (read clock domain).
//
// Sits between the dual-port RAM read port and the consumer. It synchronises
// the write Gray pointer, maintains the binary/Gray read pointers and derives
// the empty, fill-level, almost-empty and sticky underflow flags.
//
// Optional feature macro: RD_FWFT_EN
//   undefined : standard mode, rdata is the RAM output, valid the cycle after
//               an accepted rinc.
//   defined   : first-word-fall-through. A small FSM prefetches the head word
//               into an output register and rempty reflects that register.
//
// Ports:
//   r_clk, r_rst    read clock, asynchronous active-high reset
//   rinc            consumer read request
//   rempty          FIFO empty as seen by the consumer
//   ralmost_empty   rlevel <= ae_thresh
//   rlevel          words available (0 .. 2**ADDR_WIDTH)
//   ae_thresh       almost-empty threshold (quasi-static)
//   runderflow      sticky: rinc seen while rempty
//   underflow_clr   clears runderflow (a simultaneous set wins)
//   w_ptr           write Gray pointer from the write domain (asynchronous)
//   r_ptr           registered read Gray pointer to the write domain
//   raddr, ren      RAM read address / enable (synchronous RAM, 1-cycle latency)
//   mem_rdata       RAM read data
//   rdata           data to the consumer
//
// Handshake: a read is accepted in a cycle where rinc=1 and rempty=0. In
// standard mode the word appears on rdata one cycle later. In FWFT mode rdata
// already holds the head word whenever rempty=0, and rinc consumes it.
module rd_ctrl_v2 #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  rinc,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   rlevel,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  runderflow,
    input  logic                  underflow_clr,
    input  logic [ADDR_WIDTH:0]   w_ptr,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int PW = ADDR_WIDTH + 1;

    // Gray to binary: prefix XOR starting at the MSB.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          int_empty_q, int_empty_d;
    logic          ralmost_empty_q, ralmost_empty_d;
    logic          runderflow_q, runderflow_d;

    logic [PW-1:0] wq;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin_nxt;
    logic [PW-1:0] rgray_nxt;
    logic [PW-1:0] level_nxt;
    logic          pop;

    assign wq = sync_q[SYNC_STAGES-1];

    always_comb begin
        // Stage 0 samples the asynchronous pointer; later stages shift.
        sync_d = {sync_q[SYNC_STAGES-2:0], w_ptr};
        wbin      = gray2bin(wq);
        rbin_nxt  = rbin_q + {{ADDR_WIDTH{1'b0}}, pop};
        rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1);
        // Modulo subtraction on the wrap-bit pointers: a full FIFO yields
        // exactly 2**ADDR_WIDTH.
        level_nxt = wbin - rbin_nxt;

        rbin_d          = rbin_nxt;
        r_ptr_d         = rgray_nxt;
        rlevel_d        = level_nxt;
        int_empty_d     = (rgray_nxt == wq);
        ralmost_empty_d = (level_nxt <= ae_thresh);
        // Set has priority over clear.
        runderflow_d    = (rinc & rempty) | (runderflow_q & ~underflow_clr);
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            sync_q          <= '0;
            rbin_q          <= '0;
            r_ptr_q         <= '0;
            rlevel_q        <= '0;
            int_empty_q     <= 1'b1;
            ralmost_empty_q <= 1'b1;
            runderflow_q    <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            rbin_q          <= rbin_d;
            r_ptr_q         <= r_ptr_d;
            rlevel_q        <= rlevel_d;
            int_empty_q     <= int_empty_d;
            ralmost_empty_q <= ralmost_empty_d;
            runderflow_q    <= runderflow_d;
        end
    end

    assign r_ptr         = r_ptr_q;
    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_empty_q;
    assign runderflow    = runderflow_q;
    // Pre-increment address: the popped word appears on mem_rdata next cycle.
    assign raddr         = rbin_q[ADDR_WIDTH-1:0];
    assign ren           = pop;

`ifdef RD_FWFT_EN
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t                state_q;
    logic                  rempty_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Prefetch whenever the output register is free, or refill it as the
    // consumer takes the current head word.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            S_EMPTY: pop = ~int_empty_q;
            S_VALID: pop = rinc & ~int_empty_q;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_q  <= S_EMPTY;
            rempty_q <= 1'b1;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (!int_empty_q) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // RAM output for the word popped last cycle is valid now.
                    rdata_q  <= mem_rdata;
                    rempty_q <= 1'b0;
                    state_q  <= S_VALID;
                end
                S_VALID: begin
                    if (rinc) begin
                        rempty_q <= 1'b1;
                        state_q  <= int_empty_q ? S_EMPTY : S_LOAD;
                    end
                end
                default: begin
                    state_q  <= S_EMPTY;
                    rempty_q <= 1'b1;
                end
            endcase
        end
    end

    assign rempty = rempty_q;
    assign rdata  = rdata_q;
`else
    always_comb begin
        pop = rinc & ~int_empty_q;
    end

    assign rempty = int_empty_q;
    assign rdata  = mem_rdata;
`endif

endmodule

// File: doc/rd_ctrl_v2.md
Name: rd_ctrl_v2

Overview:
- Second-generation read-side controller for the async FIFO; sits in the read clock domain between the dual-port RAM read port and the consumer.
- Adds over the first generation:
  - integrated write-pointer synchroniser
  - registered Gray pointer
  - fill level
  - programmable almost-empty flag
  - sticky underflow flag
  - optional first-word-fall-through (FWFT) output stage
- Depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (extra wrap bit).

Parameters:
- ADDR_WIDTH, 4, RAM address width; depth 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.
- SYNC_STAGES, 2, flop stages on w_ptr crossing (legal 2..4).

Ports:
- r_clk  in  1  read-domain clock.
- r_rst  in  1  asynchronous, active-high reset.
- rinc  in  1  consumer read request.
- rempty  out  1  FIFO empty, as seen by consumer.
- ralmost_empty  out  1  level <= ae_thresh.
- rlevel  out  ADDR_WIDTH+1  words available, 0..2**ADDR_WIDTH.
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static.
- runderflow  out  1  sticky: rinc seen while rempty.
- underflow_clr  in  1  clears runderflow.
- w_ptr  in  ADDR_WIDTH+1  write Gray pointer, asynchronous (write domain).
- r_ptr  out  ADDR_WIDTH+1  registered read Gray pointer, to write domain.
- raddr  out  ADDR_WIDTH  RAM read address = rbin[ADDR_WIDTH-1:0].
- ren  out  1  RAM read enable; RAM read is synchronous, 1-cycle latency.
- mem_rdata  in  DATA_WIDTH  RAM read data.
- rdata  out  DATA_WIDTH  data to consumer.

Behaviour:
- Reset state (r_rst high, async):
  - all flops 0, except rempty=1 and ralmost_empty=1.
  - rlevel=0, r_ptr=0, raddr=0, runderflow=0, ren=0.
  - Reset mid-operation drops any in-flight word.
- Synchroniser: w_ptr passes through SYNC_STAGES flops -> wq (Gray). wq is converted to binary wbin combinationally (prefix XOR from MSB).
- Pointer update:
  - pop = internal read strobe; in standard mode pop = rinc & ~rempty.
  - rbin_nxt = rbin + pop, modulo 2**(ADDR_WIDTH+1).
  - rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1).
  - rbin and r_ptr both register the _nxt values. r_ptr is a flop output, glitch-free.
- Flags, all registered from _nxt values, so they update in the same edge as the pointer:
  - int_empty <= (rgray_nxt == wq).
  - rlevel <= wbin - rbin_nxt, ADDR_WIDTH+1-bit modulo subtraction. Full FIFO gives 2**ADDR_WIDTH. Wrap of pointer MSB is handled by modulo arithmetic.
  - ralmost_empty <= (level_nxt <= ae_thresh). ae_thresh=0 means almost-empty only when empty.
- ren = pop. raddr is the pre-increment rbin, so the RAM outputs the popped word on mem_rdata one cycle after pop.
- Underflow:
  - rinc & rempty sets runderflow next edge. Pointer does not move.
  - underflow_clr clears it. Set wins if both occur in the same cycle.
- Simultaneous write arrival and pop: level_nxt uses the current wq, so the level stays consistent.
- Write-side updates appear on rempty/rlevel SYNC_STAGES+1 cycles after w_ptr changes.

Optional Feature:
- Macro: RD_FWFT_EN.
- Without it (standard mode):
  - rempty = int_empty.
  - rdata = mem_rdata (pass-through); data is valid the cycle after rinc is accepted.
- With it (FWFT), 3-state FSM:
  - S_EMPTY: rempty=1. If ~int_empty: pop=1 (ren), go to S_LOAD.
  - S_LOAD: rempty=1. Capture mem_rdata into rdata register at the edge; go to S_VALID.
  - S_VALID: rempty=0, rdata holds the head word.
    - On rinc: if ~int_empty, pop=1 and go to S_LOAD (one-cycle bubble); else go to S_EMPTY.
    - Without rinc: hold.
- In FWFT mode pop is FSM-driven and rinc is ignored except in S_VALID.
- rlevel excludes the word held in the output register.
- Underflow: rinc while rempty=1 sets runderflow in either mode.
- Reset returns the FSM to S_EMPTY and rdata to 0.

Test Plan (ADDR_WIDTH=4, SYNC_STAGES=2):
- Reset, no writes -> rempty=1, ralmost_empty=1, rlevel=0, r_ptr=0, ren=0.
- Write pointer steps 0->3 (Gray 0,1,3,2) -> 3 cycles after the last step: rempty=0, rlevel=3. Three rinc pulses -> raddr 0,1,2; r_ptr 1,3,2; rempty=1 after the third.
- w_ptr = Gray(16) (full), ae_thresh=4 -> rlevel=16, ralmost_empty=0. Pop 12 words -> rlevel=4, ralmost_empty=1.
- Wrap: read 20 words through a refilled FIFO -> rbin goes 31->0, r_ptr goes 10000b->00000b, rlevel stays correct.
- rinc while empty -> runderflow=1, raddr unchanged. underflow_clr with simultaneous rinc&rempty -> runderflow stays 1.
- RD_FWFT_EN, one word 0xA5 written:
  - ren pulses without rinc; rempty falls 2 cycles later with rdata=0xA5.
  - rinc -> rempty=1 next cycle.
  - r_rst asserted in S_LOAD -> S_EMPTY, rdata=0.
